// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified-memory port arbiter: FSM state, access owner,
// and the fixed-priority request pick used in IDLE.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_IF   = 2'b01,
    ARB_DM   = 2'b10,
    ARB_DONE = 2'b11
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  typedef struct packed {
    logic   grant;
    owner_e owner;
    logic   wr;
  } arb_pick_t;

  // Data port holds the older instruction, so it wins; rd&wr together is an error, never a grant.
  function automatic arb_pick_t arb_pick(input logic if_req, input logic dm_rd, input logic dm_wr);
    arb_pick_t p;
    p.grant = 1'b0;
    p.owner = OWN_IF;
    p.wr    = 1'b0;
    if (dm_rd ^ dm_wr) begin
      p.grant = 1'b1;
      p.owner = OWN_DM;
      p.wr    = dm_wr;
    end else if (if_req) begin
      p.grant = 1'b1;
    end
    return p;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_lat_counter.sv
// Access latency counter: synchronous clear and enable, reset dominant.
module lat_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst)      count <= '0;
    else if (clr) count <= '0;
    else if (en)  count <= count + W'(1);
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-ported memory between the fetch and data ports;
// one access at a time, sequenced IDLE -> BUSY -> DONE with a registered done pulse.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int LATENCY = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  output logic          if_stall,
  input  logic          dm_rd,
  input  logic          dm_wr,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_done,
  output logic          dm_stall,
  output logic          err,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_rd,
  output logic          mem_wr,
  input  logic [DW-1:0] mem_rdata
);

  localparam int             CW       = $clog2(LATENCY + 2);
  localparam logic [CW-1:0]  CNT_LAST = CW'(LATENCY + 1);

  typedef struct packed {
    owner_e        owner;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } acc_t;

  arb_state_e    state;
  acc_t          acc;
  arb_pick_t     pick;
  logic [CW-1:0] count;
  logic          busy;
  logic          last;
  logic          cnt_en;

  assign pick   = arb_pick(if_req, dm_rd, dm_wr);
  assign busy   = (state == ARB_IF) || (state == ARB_DM);
  assign last   = busy && (count == CNT_LAST);
  // Counting from the grant edge puts count=1 in the first BUSY cycle.
  assign cnt_en = ((state == ARB_IDLE) && pick.grant) || busy;

  lat_counter #(.W(CW)) u_lat_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (last),
    .en    (cnt_en),
    .count (count)
  );

  assign err       = dm_rd & dm_wr;
  assign if_stall  = if_req & ~if_done;
  assign dm_stall  = (dm_rd | dm_wr) & ~dm_done & ~err;
  assign mem_addr  = acc.addr;
  assign mem_wdata = acc.wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB_IDLE;
      acc      <= '0;
      mem_rd   <= 1'b0;
      mem_wr   <= 1'b0;
      if_done  <= 1'b0;
      dm_done  <= 1'b0;
      if_rdata <= '0;
      dm_rdata <= '0;
    end else begin
      mem_rd  <= 1'b0;
      mem_wr  <= 1'b0;
      if_done <= 1'b0;
      dm_done <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (pick.grant) begin
            acc.owner <= pick.owner;
            acc.wr    <= pick.wr;
            acc.addr  <= (pick.owner == OWN_DM) ? dm_addr : if_addr;
            acc.wdata <= dm_wdata;
            mem_rd    <= ~pick.wr;
            mem_wr    <= pick.wr;
            state     <= (pick.owner == OWN_DM) ? ARB_DM : ARB_IF;
          end
        end
        ARB_IF, ARB_DM: begin
          if (last) begin
            if (!acc.wr) begin
              if (acc.owner == OWN_DM) dm_rdata <= mem_rdata;
              else                     if_rdata <= mem_rdata;
            end
            if_done <= (acc.owner == OWN_IF);
            dm_done <= (acc.owner == OWN_DM);
            state   <= ARB_DONE;
          end
        end
        ARB_DONE: state <= ARB_IDLE;
        default:  state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: directed scenarios plus randomized requesters, checked every
// cycle against a transaction-level model (grant cycle g -> strobe g+1, done g+L+2).
module tb_mem_port_arbiter;
  localparam int AW = 16, DW = 16, LAT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, dm_rd, dm_wr;
  logic [AW-1:0] if_addr, dm_addr, mem_addr;
  logic [DW-1:0] dm_wdata, if_rdata, dm_rdata, mem_wdata, mem_rdata;
  logic          if_done, if_stall, dm_done, dm_stall, err, mem_rd, mem_wr;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
    .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
    .dm_done(dm_done), .dm_stall(dm_stall), .err(err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata)
  );

  int n_chk = 0, n_fail = 0, cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // transaction-level model
  bit        t_act = 0, t_dm = 0, t_wr = 0;
  logic [15:0] t_addr = '0, t_wdata = '0;
  int        t_g = 0;
  logic [15:0] m_if_rdata = '0, m_dm_rdata = '0;
  bit        rst_prev = 1, if_done_prev = 0, dm_done_prev = 0;
  // memory model history, indexed by cycle mod 8
  int        hist_cyc [8];
  logic [15:0] hist_addr [8];
  bit        hist_v [8];
  // DUT observations from the last step
  logic      obs_if_done, obs_dm_done, obs_mem_rd, obs_mem_wr, obs_err, obs_dm_stall;
  logic [15:0] obs_if_rdata, obs_dm_rdata, obs_mem_addr, obs_mem_wdata;

  task automatic step();
    int   slot;
    bit   e_mrd, e_mwr, e_busy, done, was_act;
    slot = (cyc - LAT) & 7;
    if (cyc >= LAT && hist_v[slot] && hist_cyc[slot] == cyc - LAT) mem_rdata = hist_addr[slot] ^ 16'hA5A5;
    else mem_rdata = 16'($urandom);
    if (rst_prev) begin m_if_rdata = '0; m_dm_rdata = '0; end
    e_mrd  = t_act && cyc == t_g + 1 && !t_wr;
    e_mwr  = t_act && cyc == t_g + 1 && t_wr;
    e_busy = t_act && cyc > t_g && cyc <= t_g + LAT + 2;
    done   = t_act && cyc == t_g + LAT + 2;
    if (done && !t_wr) begin
      if (t_dm) m_dm_rdata = t_addr ^ 16'hA5A5;
      else      m_if_rdata = t_addr ^ 16'hA5A5;
    end
    @(negedge clk);
    hist_v[cyc & 7] = mem_rd; hist_cyc[cyc & 7] = cyc; hist_addr[cyc & 7] = mem_addr;
    obs_if_done = if_done; obs_dm_done = dm_done; obs_mem_rd = mem_rd; obs_mem_wr = mem_wr;
    obs_err = err; obs_dm_stall = dm_stall; obs_if_rdata = if_rdata; obs_dm_rdata = dm_rdata;
    obs_mem_addr = mem_addr; obs_mem_wdata = mem_wdata;
    chk("mem_rd", mem_rd, e_mrd);
    chk("mem_wr", mem_wr, e_mwr);
    chk("if_done", if_done, done && !t_dm);
    chk("dm_done", dm_done, done && t_dm);
    chk("if_rdata", if_rdata, m_if_rdata);
    chk("dm_rdata", dm_rdata, m_dm_rdata);
    chk("err", err, dm_rd && dm_wr);
    chk("if_stall", if_stall, if_req && !(done && !t_dm));
    chk("dm_stall", dm_stall, (dm_rd || dm_wr) && !(done && t_dm) && !(dm_rd && dm_wr));
    if (e_busy) chk("mem_addr", mem_addr, t_addr);
    if (e_mwr)  chk("mem_wdata", mem_wdata, t_wdata);
    was_act = t_act;
    if (done) t_act = 0;
    if (rst) t_act = 0;
    else if (!was_act && (dm_rd ^ dm_wr)) begin
      t_act = 1; t_dm = 1; t_wr = dm_wr; t_addr = dm_addr; t_wdata = dm_wdata; t_g = cyc;
    end else if (!was_act && if_req) begin
      t_act = 1; t_dm = 0; t_wr = 0; t_addr = if_addr; t_g = cyc;
    end
    if_done_prev = done && !t_dm;
    dm_done_prev = done && t_dm;
    rst_prev     = rst;
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    if_req = 0; dm_rd = 0; dm_wr = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  int err_cnt = 0;

  task automatic new_dm();
    int r;
    r = $urandom_range(0, 9);
    dm_addr = 16'($urandom); dm_wdata = 16'($urandom);
    if (r == 0) begin dm_rd = 1; dm_wr = 1; err_cnt = $urandom_range(1, 4); end
    else if (r < 5) begin dm_rd = 1; dm_wr = 0; end
    else begin dm_rd = 0; dm_wr = 1; end
  endtask

  initial begin
    int last;
    rst = 1; if_req = 0; if_addr = '0; dm_rd = 0; dm_wr = 0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
    for (int i = 0; i < 8; i++) begin hist_v[i] = 0; hist_cyc[i] = -1; hist_addr[i] = '0; end
    @(posedge clk); #1;
    step(); step();
    rst = 0;
    idle(2);

    // single fetch
    if_req = 1; if_addr = 16'h0010;
    for (int k = 0; k < 12; k++) begin
      if (if_done_prev) if_req = 0;
      step();
      if (obs_if_done) begin chk("t1_done_cyc", k, 6); chk("t1_rdata", obs_if_rdata, 16'hA5B5); end
      if (obs_mem_rd)  begin chk("t1_rd_cyc", k, 1); chk("t1_addr", obs_mem_addr, 16'h0010); end
    end
    idle(2);

    // both ports at once: data first
    if_req = 1; if_addr = 16'h0040; dm_rd = 1; dm_addr = 16'h0100;
    for (int k = 0; k < 18; k++) begin
      if (if_done_prev) if_req = 0;
      if (dm_done_prev) dm_rd = 0;
      step();
      if (obs_dm_done) chk("t2_dm_done_cyc", k, 6);
      if (obs_if_done) chk("t2_if_done_cyc", k, 13);
      if (obs_mem_rd)  chk("t2_rd_cyc", (k == 1 || k == 8), 1);
    end
    idle(2);

    // write leaves dm_rdata alone
    dm_wr = 1; dm_addr = 16'h0200; dm_wdata = 16'hBEEF;
    for (int k = 0; k < 10; k++) begin
      if (dm_done_prev) dm_wr = 0;
      step();
      if (obs_mem_wr)  begin chk("t3_wr_cyc", k, 1); chk("t3_wdata", obs_mem_wdata, 16'hBEEF); end
      if (obs_dm_done) begin chk("t3_done_cyc", k, 6); chk("t3_rdata_kept", obs_dm_rdata, 16'hA4A5); end
    end
    idle(2);

    // rd&wr together: error, fetch still served
    dm_rd = 1; dm_wr = 1; dm_addr = 16'h0300; if_req = 1; if_addr = 16'h0300;
    for (int k = 0; k < 10; k++) begin
      if (if_done_prev) if_req = 0;
      step();
      chk("t4_err", obs_err, 1);
      chk("t4_dm_stall", obs_dm_stall, 0);
      if (obs_if_done) chk("t4_if_done_cyc", k, 6);
    end
    idle(2);

    // reset in cycle 3 of a fetch
    if_req = 1; if_addr = 16'h0400;
    for (int k = 0; k < 14; k++) begin
      if (if_done_prev) if_req = 0;
      rst = (k == 3);
      step();
      rst = 0;
      if (obs_if_done) chk("t5_done_cyc", k, 10);
    end
    idle(2);

    // back-to-back fetches
    last = -1;
    if_req = 1; if_addr = 16'($urandom);
    for (int k = 0; k < 30; k++) begin
      if (if_done_prev) if_addr = 16'($urandom);
      step();
      if (obs_if_done) begin chk("t6_period", k, last + 7); last = k; end
    end
    idle(3);

    // randomized traffic
    for (int n = 0; n < 2500; n++) begin
      if (if_req && if_done_prev) begin
        if ($urandom_range(0, 1) == 0) if_req = 0; else if_addr = 16'($urandom);
      end else if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1; if_addr = 16'($urandom);
      end
      if (err_cnt > 0) begin
        err_cnt--;
        if (err_cnt == 0) begin dm_rd = 0; dm_wr = 0; end
      end else if ((dm_rd || dm_wr) && dm_done_prev) begin
        if ($urandom_range(0, 1) == 0) begin dm_rd = 0; dm_wr = 0; end else new_dm();
      end else if (!(dm_rd || dm_wr) && $urandom_range(0, 2) == 0) begin
        new_dm();
      end
      rst = ($urandom_range(0, 79) == 0);
      step();
    end
    rst = 0;
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
